// File: rtl/sol_result_printer.sv
// sol_result_printer
//   Downstream stage of the per-day solver core. Accepts one unsigned binary
//   result per handshake and converts it to decimal using iterative
//   shift-add-3 (double dabble). The decimal value is then streamed as ASCII,
//   most significant digit first, with leading zeros suppressed. A line
//   terminator follows the digits.
//
//   Optional feature macro: SOL_RESULT_PRINTER_CRLF_EN
//     defined   : line ends with 8'h0D then 8'h0A (extra TERM_LF state)
//     undefined : line ends with 8'h0A only
//
// Parameters
//   WIDTH  - bit width of result_in
//   DIGITS - BCD digits held; must be >= ceil(WIDTH*log10(2))
//
// Ports
//   clk          - clock
//   rst_n        - asynchronous active-low reset
//   result_in    - binary value to print (unsigned)
//   result_valid - result_in valid
//   result_ready - block idle and able to accept a value
//   char_out     - ASCII character
//   char_valid   - char_out valid
//   char_ready   - sink accepts char_out
//   busy         - conversion or emission in progress
module sol_result_printer #(
  parameter int WIDTH  = 64,
  parameter int DIGITS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] result_in,
  input  logic             result_valid,
  output logic             result_ready,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy
);

  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SKIP,
    S_EMIT,
    S_TERM
`ifdef SOL_RESULT_PRINTER_CRLF_EN
    , S_TERM_LF
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [BW-1:0]    bcd_adj;
  logic [3:0]       cur_digit;

  // Add-3 correction applied to every digit before each shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign cur_digit = bcd_q[4*int'(ptr_q) +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    result_ready = 1'b0;
    char_valid   = 1'b0;
    char_out     = 8'h00;

    case (state_q)
      S_IDLE: begin
        result_ready = 1'b1;
        if (result_valid) begin
          shift_d = result_in;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_CONVERT;
        end
      end

      // Counter runs WIDTH..1 for the shift steps; the cycle that sees zero
      // only hands over to the digit scan.
      S_CONVERT: begin
        if (cnt_q == '0) begin
          ptr_d   = PW'(DIGITS - 1);
          state_d = S_SKIP;
        end else begin
          {bcd_d, shift_d} = {bcd_adj[BW-2:0], shift_q, 1'b0};
          cnt_d            = cnt_q - 1'b1;
        end
      end

      // Digit 0 is never skipped so a zero value still prints "0".
      S_SKIP: begin
        if (cur_digit == 4'd0 && ptr_q != '0) begin
          ptr_d = ptr_q - 1'b1;
        end else begin
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        char_valid = 1'b1;
        char_out   = 8'h30 + {4'h0, cur_digit};
        if (char_ready) begin
          if (ptr_q == '0) begin
            state_d = S_TERM;
          end else begin
            ptr_d = ptr_q - 1'b1;
          end
        end
      end

`ifdef SOL_RESULT_PRINTER_CRLF_EN
      S_TERM: begin
        char_valid = 1'b1;
        char_out   = 8'h0D;
        if (char_ready) state_d = S_TERM_LF;
      end

      S_TERM_LF: begin
        char_valid = 1'b1;
        char_out   = 8'h0A;
        if (char_ready) state_d = S_IDLE;
      end
`else
      S_TERM: begin
        char_valid = 1'b1;
        char_out   = 8'h0A;
        if (char_ready) state_d = S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = !result_ready;

endmodule

// File: tb/tb_sol_result_printer.sv
module tb_sol_result_printer;

  localparam int WIDTH  = 64;
  localparam int DIGITS = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] result_in;
  logic             result_valid;
  logic             result_ready;
  logic [7:0]       char_out;
  logic             char_valid;
  logic             char_ready;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sol_result_printer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result_in    (result_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .busy         (busy)
  );

  // Present a value for exactly one acceptance edge; returns at edge+1.
  task automatic accept(input logic [WIDTH-1:0] v);
    result_in    = v;
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
  endtask

  // Count edges after acceptance until char_valid is seen.
  task automatic wait_char(output int n);
    n = 0;
    while (!char_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Gather handshaken characters until LF; bounded by max_cycles.
  task automatic collect(input int max_cycles, output logic [191:0] b,
                         output int len, output bit timed_out);
    bit last;
    b = '0; len = 0; timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      last = 1'b0;
      if (char_valid && char_ready) begin
        b = {b[183:0], char_out};
        len++;
        last = (char_out == 8'h0A);
      end
      @(posedge clk); #1;
      if (last) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; result_valid = 1'b0; result_in = '0; char_ready = 1'b1;
    #12;
    n_checks += 4;
    if (result_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", result_ready); end
    if (char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cvalid got %b want 0", char_valid); end
    if (char_out !== 8'h00) begin n_fail++; $display("FAIL reset_cout got %h want 00", char_out); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset done");
  endtask

  task automatic test_basic();
    int n, len; bit to; logic [191:0] b, exp;
    char_ready = 1'b1;
    accept(64'd4361);
    n_checks += 2;
    if (result_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop got %b want 0", result_ready); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_char(n);
    n_checks++;
    if (n != 82) begin n_fail++; $display("FAIL basic_latency got %0d want 82", n); end
    collect(50, b, len, to);
    exp = "4361\n";
    n_checks += 3;
    if (to || b !== exp) begin n_fail++; $display("FAIL basic_stream got %h want %h", b, exp); end
    if (len != 5) begin n_fail++; $display("FAIL basic_len got %0d want 5", len); end
    if (result_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back got %b want 1", result_ready); end
    $display("4361: latency %0d, %0d chars", n, len);
  endtask

  task automatic test_zero();
    int n, len; bit to; logic [191:0] b, exp;
    accept(64'd0);
    wait_char(n);
    collect(50, b, len, to);
    exp = "0\n";
    n_checks += 3;
    if (n != 85) begin n_fail++; $display("FAIL zero_latency got %0d want 85", n); end
    if (to || b !== exp) begin n_fail++; $display("FAIL zero_stream got %h want %h", b, exp); end
    if (len != 2) begin n_fail++; $display("FAIL zero_len got %0d want 2", len); end
    $display("zero: latency %0d, %0d chars", n, len);
  endtask

  task automatic test_max();
    int n, len; bit to; logic [191:0] b, exp;
    accept(64'hFFFF_FFFF_FFFF_FFFF);
    wait_char(n);
    collect(60, b, len, to);
    exp = "18446744073709551615\n";
    n_checks += 3;
    if (n != 66) begin n_fail++; $display("FAIL max_latency got %0d want 66", n); end
    if (to || b !== exp) begin n_fail++; $display("FAIL max_stream got %h want %h", b, exp); end
    if (len != 21) begin n_fail++; $display("FAIL max_len got %0d want 21", len); end
    $display("max: latency %0d, %0d chars", n, len);
  endtask

  task automatic test_backpressure();
    int n, len; bit stalled, last, done; logic [191:0] b, exp;
    accept(64'd507);
    wait_char(n);
    b = '0; len = 0; stalled = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (char_valid && char_out == 8'h30 && !stalled) begin
        stalled = 1'b1;
        char_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          n_checks++;
          if (char_valid !== 1'b1 || char_out !== 8'h30) begin
            n_fail++;
            $display("FAIL bp_hold cyc %0d got v=%b c=%h want v=1 c=30", k, char_valid, char_out);
          end
        end
        char_ready = 1'b1;
      end
      last = 1'b0;
      if (char_valid && char_ready) begin
        b = {b[183:0], char_out}; len++;
        last = (char_out == 8'h0A);
      end
      @(posedge clk); #1;
      done = last;
    end
    exp = "507\n";
    n_checks += 2;
    if (!done || b !== exp) begin n_fail++; $display("FAIL bp_stream got %h want %h", b, exp); end
    if (len != 4) begin n_fail++; $display("FAIL bp_len got %0d want 4", len); end
    $display("507 with stall: %0d chars", len);
  endtask

  task automatic test_ignore_input();
    int n, len; bit to; logic [191:0] b, exp;
    accept(64'd12);
    repeat (5) begin @(posedge clk); #1; end
    result_in = 64'd99; result_valid = 1'b1;
    n_checks++;
    if (result_ready !== 1'b0) begin n_fail++; $display("FAIL ign_convert_ready got %b want 0", result_ready); end
    @(posedge clk); #1;
    result_valid = 1'b0;
    wait_char(n);
    char_ready = 1'b0; result_valid = 1'b1;
    n_checks++;
    if (result_ready !== 1'b0) begin n_fail++; $display("FAIL ign_emit_ready got %b want 0", result_ready); end
    @(posedge clk); #1;
    result_valid = 1'b0; char_ready = 1'b1;
    collect(20, b, len, to);
    exp = "12\n";
    n_checks++;
    if (to || b !== exp) begin n_fail++; $display("FAIL ign_stream got %h want %h", b, exp); end
    repeat (3) begin @(posedge clk); #1; end
    n_checks += 2;
    if (result_ready !== 1'b1) begin n_fail++; $display("FAIL ign_idle_ready got %b want 1", result_ready); end
    if (char_valid !== 1'b0) begin n_fail++; $display("FAIL ign_idle_cvalid got %b want 0", char_valid); end
    $display("12 with ignored 99: %0d chars", len);
  endtask

  task automatic test_midreset();
    int n, len; bit to, seen3; logic [191:0] b, exp;
    accept(64'd123456);
    wait_char(n);
    seen3 = 1'b0;
    for (int i = 0; i < 10 && !seen3; i++) begin
      if (char_valid && char_ready && char_out == 8'h33) seen3 = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (!seen3) begin n_fail++; $display("FAIL mr_saw3 got 0 want 1"); end
    if (char_valid !== 1'b0) begin n_fail++; $display("FAIL mr_cvalid got %b want 0", char_valid); end
    if (result_ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready got %b want 1", result_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    accept(64'd7);
    wait_char(n);
    collect(20, b, len, to);
    exp = "7\n";
    n_checks += 2;
    if (n != 85) begin n_fail++; $display("FAIL mr_7_latency got %0d want 85", n); end
    if (to || b !== exp) begin n_fail++; $display("FAIL mr_7_stream got %h want %h", b, exp); end
    $display("reset mid-line then 7: %0d chars", len);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_backpressure();
    test_ignore_input();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
